// File: rtl/lmsm_sequencer_if.sv
// Bundle between the LM/SM sequencer, the register file and data memory.
// The pipeline/memory side uses the master modport; the sequencer uses slave.
interface lmsm_sequencer_if #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16
) ();
   logic              start;
   logic              is_lm;
   logic [7:0]        imm_mask;
   logic [ADDR_W-1:0] base_addr;
   logic              mem_ready;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] reg_rdata;
   logic              busy;
   logic              done;
   logic [2:0]        reg_addr;
   logic              reg_we;
   logic [DATA_W-1:0] reg_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_re;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic              r7_written;

   modport slave (
      input  start, is_lm, imm_mask, base_addr, mem_ready, mem_rdata, reg_rdata,
      output busy, done, reg_addr, reg_we, reg_wdata, mem_addr, mem_re, mem_we,
             mem_wdata, r7_written
   );

   modport master (
      output start, is_lm, imm_mask, base_addr, mem_ready, mem_rdata, reg_rdata,
      input  busy, done, reg_addr, reg_we, reg_wdata, mem_addr, mem_re, mem_we,
             mem_wdata, r7_written
   );
endinterface

// File: rtl/lmsm_sequencer.sv
// LM/SM sequencer: walks an 8-bit register mask from R0 up to R7 and issues
// one data-memory access per set bit, stalling upstream while it works.
module lmsm_sequencer #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 16,
   parameter int ADDR_INC = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   lmsm_sequencer_if.slave     bus,
   output logic [1:0]          dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_XFER = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [7:0]        mask_q, mask_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              op_q, op_d;

   logic [2:0]        cur;
   logic [7:0]        cur_onehot;

   // Lowest set bit wins, so registers are transferred in ascending order.
   always_comb begin
      cur = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i]) cur = 3'(i);
      end
      cur_onehot = 8'b0000_0001 << cur;
   end

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      addr_d  = addr_q;
      op_d    = op_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               mask_d  = bus.imm_mask;
               addr_d  = bus.base_addr;
               op_d    = bus.is_lm;
               state_d = (bus.imm_mask != 8'h00) ? ST_XFER : ST_DONE;
            end
         end
         ST_XFER: begin
            if (bus.mem_ready) begin
               mask_d = mask_q & ~cur_onehot;
               addr_d = addr_q + ADDR_W'(ADDR_INC);
               if (mask_d == 8'h00) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         mask_q  <= 8'h00;
         addr_q  <= '0;
         op_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         addr_q  <= addr_d;
         op_q    <= op_d;
      end
   end

   // Memory handshake: the strobe (mem_re/mem_we) with its address is the
   // request; it stays asserted and unchanged until mem_ready is seen high in
   // the same cycle, which completes that access (and lands the LM write).
   always_comb begin
      bus.busy       = 1'b0;
      bus.done       = (state_q == ST_DONE);
      bus.reg_addr   = 3'd0;
      bus.reg_we     = 1'b0;
      bus.mem_addr   = '0;
      bus.mem_re     = 1'b0;
      bus.mem_we     = 1'b0;
      bus.r7_written = 1'b0;
      if (state_q == ST_XFER) begin
         bus.busy       = 1'b1;
         bus.reg_addr   = cur;
         bus.mem_addr   = addr_q;
         bus.mem_re     = op_q;
         bus.mem_we     = ~op_q;
         bus.reg_we     = op_q & bus.mem_ready;
         bus.r7_written = op_q & bus.mem_ready & (cur == 3'd7);
      end
   end

   assign bus.reg_wdata = DATA_W'(bus.mem_rdata);
   assign bus.mem_wdata = DATA_W'(bus.reg_rdata);
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Self-checking bench for lmsm_sequencer: expected transfers are queued when
// an operation is launched and retired as the sequencer issues accesses.
module tb_lmsm_sequencer;

   logic       clk;
   logic       rst_n;
   logic [1:0] dbg_state;

   lmsm_sequencer_if #(.DATA_W(16), .ADDR_W(16)) bus ();

   lmsm_sequencer #(.DATA_W(16), .ADDR_W(16), .ADDR_INC(1)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard ----------------
   // entry = {is_lm, reg index[2:0], mem address[15:0]}
   logic [19:0] exp_q[$];
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_flags"}, 32'({bus.busy, bus.done, bus.reg_we, bus.mem_re,
                                  bus.mem_we, bus.r7_written}), 32'd0);
      check({tag, "_reg_addr"}, 32'(bus.reg_addr), 32'd0);
      check({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, "_state"}, 32'(dbg_state), 32'd0);
   endtask

   // Monitor: every strobed cycle is compared against the oldest pending
   // transfer; it retires only when memory reports ready.
   always @(negedge clk) begin
      logic [19:0] e;
      if (bus.mem_re === 1'b1 || bus.mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'({bus.mem_re, bus.mem_we}), 32'd0);
         end else begin
            e = exp_q[0];
            check("strobes", 32'({bus.mem_re, bus.mem_we}), e[19] ? 32'd2 : 32'd1);
            check("reg_addr", 32'(bus.reg_addr), 32'(e[18:16]));
            check("mem_addr", 32'(bus.mem_addr), 32'(e[15:0]));
            check("busy_xfer", 32'(bus.busy), 32'd1);
            check("reg_we", 32'(bus.reg_we), 32'(e[19] & bus.mem_ready));
            check("r7_written", 32'(bus.r7_written),
                  32'(e[19] & bus.mem_ready & (e[18:16] == 3'd7)));
            if (e[19]) check("reg_wdata", 32'(bus.reg_wdata), 32'(bus.mem_rdata));
            else       check("mem_wdata", 32'(bus.mem_wdata), 32'(bus.reg_rdata));
            if (bus.mem_ready) void'(exp_q.pop_front());
         end
      end else if (bus.reg_we === 1'b1 || bus.r7_written === 1'b1) begin
         check("stray_reg_write", 32'({bus.reg_we, bus.r7_written}), 32'd0);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_data();
      bus.mem_rdata = 16'($urandom);
      bus.reg_rdata = 16'($urandom);
   endtask

   // Launch one LM/SM; memory is ready once every stall+1 cycles.
   // poke re-asserts start mid-operation, which must be ignored.
   task automatic run_op(input logic op, input logic [7:0] mask, input logic [15:0] base,
                         input int stall, input bit poke);
      logic [15:0] a;
      int pc, cyc, bcnt;
      bit got;
      a  = base;
      pc = 0;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) begin
            exp_q.push_back({op, 3'(i), a});
            a = a + 16'd1;
            pc++;
         end
      end
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.is_lm     = op;
      bus.imm_mask  = mask;
      bus.base_addr = base;
      bus.mem_ready = 1'b1;
      drive_data();
      @(negedge clk);
      check("launch_done_low", 32'(bus.done), 32'd0);
      check("launch_busy_low", 32'(bus.busy), 32'd0);
      cyc  = 0;
      bcnt = 0;
      got  = 1'b0;
      while (!got && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
         bus.start     = poke && (cyc == 2);
         bus.imm_mask  = (poke && (cyc == 2)) ? ~mask : mask;
         bus.is_lm     = (poke && (cyc == 2)) ? ~op : op;
         bus.mem_ready = ((cyc % (stall + 1)) == 0);
         drive_data();
         @(negedge clk);
         if (bus.busy) bcnt++;
         if (bus.done) got = 1'b1;
      end
      bus.start = 1'b0;
      check("done_seen", 32'(got), 32'd1);
      check("latency", 32'(cyc), 32'(pc * (stall + 1) + 1));
      check("busy_cycles", 32'(bcnt), 32'(pc * (stall + 1)));
      check("all_transfers", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int dcnt;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.is_lm     = 1'b0;
      bus.imm_mask  = 8'h00;
      bus.base_addr = 16'h0000;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = 16'h0000;
      bus.reg_rdata = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;

      run_op(1'b1, 8'b1000_0101, 16'h0040, 0, 1'b0);   // LM R0,R2,R7
      run_op(1'b0, 8'hFF,        16'h0100, 0, 1'b0);   // SM all registers
      run_op(1'b1, 8'h12,        16'h0200, 3, 1'b0);   // LM with stalls
      run_op(1'b1, 8'h00,        16'h0300, 0, 1'b0);   // empty mask
      run_op(1'b0, 8'h03,        16'hFFFF, 0, 1'b0);   // address wrap
      run_op(1'b1, 8'h81,        16'h0500, 1, 1'b1);   // start ignored mid-op
      run_op(1'b0, 8'h80,        16'h0600, 0, 1'b1);   // start ignored in DONE

      // Reset during the second transfer of mask 0F aborts the operation.
      exp_q.push_back({1'b1, 3'd0, 16'h0300});
      exp_q.push_back({1'b1, 3'd1, 16'h0301});
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.is_lm     = 1'b1;
      bus.imm_mask  = 8'h0F;
      bus.base_addr = 16'h0300;
      bus.mem_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      bus.mem_ready = 1'b0;
      rst_n         = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check_quiet("abort");
      check("abort_pending", 32'(exp_q.size()), 32'd1);
      exp_q.delete();
      rst_n         = 1'b1;
      bus.mem_ready = 1'b1;
      dcnt = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done || bus.busy) dcnt++;
      end
      check("abort_no_done", 32'(dcnt), 32'd0);
      run_op(1'b1, 8'h05, 16'h0700, 0, 1'b0);         // restart after abort

      for (int k = 0; k < 8; k++) begin
         run_op(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                16'($urandom_range(0, 65535)), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
